// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Parallel-to-serial front end for the sequence-detector path. WIDTH-bit words
// are accepted over a valid/ready handshake and shifted out MSB-first, one bit
// per clock, on a single serial line. Words stream back-to-back with no idle
// gap, so bit patterns that cross word boundaries stay intact.
//
// Optional feature macro: SERIALIZER_PARITY_EN
//   defined     : each word is followed by one even-parity bit (XOR of all
//                 WIDTH data bits), carried with sout_valid=1 and last=1.
//   not defined : no parity state or logic; zero-bubble streaming of WIDTH-bit
//                 words.
//
// Handshake: a word is accepted at a posedge where din_valid && din_ready.
// din_ready is decoded from registered state only; upstream holds din and
// din_valid stable until the word is accepted. din_valid while din_ready=0 is
// ignored.
//
// Parameters:
//   WIDTH       word width in bits (2..32)
//   IDLE_BIT    level driven on sout when no word is being shifted
//
// Ports:
//   clk          clock, all state updates on posedge
//   rstn         asynchronous active-low reset
//   din          parallel word, sampled on accept
//   din_valid    din holds a word
//   din_ready    block can accept a word this cycle
//   sout         serial bit (feeds the detector's serial input)
//   sout_valid   sout carries a data/parity bit rather than the idle level
//   last         current sout bit is the final bit of its word
//   busy         FSM is not in IDLE
//   dbg_state_o  raw FSM state, for observation only
// -----------------------------------------------------------------------------
module bit_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy,
    output logic [1:0]       dbg_state_o
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1
    } state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
`ifdef SERIALIZER_PARITY_EN
    logic             par_q,   par_d;
`endif

    // State register. Reset discards any partial word immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state and output decode. Outputs depend on registered state only;
    // din/din_valid influence only the *_d values.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
`ifdef SERIALIZER_PARITY_EN
        par_d      = par_q;
`endif
        din_ready  = 1'b0;
        sout       = IDLE_BIT;
        sout_valid = 1'b0;
        last       = 1'b0;

        case (state_q)
            S_IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    shreg_d = din;
                    cnt_d   = CNT_LOAD;
`ifdef SERIALIZER_PARITY_EN
                    par_d   = 1'b0;
`endif
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                sout       = shreg_q[WIDTH-1];
                sout_valid = 1'b1;
                shreg_d    = shreg_q << 1;
`ifdef SERIALIZER_PARITY_EN
                // Parity accumulates over the bits as they leave, so it is
                // complete exactly when the last data bit has been sent.
                par_d = par_q ^ shreg_q[WIDTH-1];
                if (cnt_q == '0) begin
                    state_d = S_PARITY;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
`else
                if (cnt_q == '0) begin
                    last      = 1'b1;
                    din_ready = 1'b1;
                    // Reload on the last bit keeps the stream gap-free.
                    if (din_valid) begin
                        shreg_d = din;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
`endif
            end

`ifdef SERIALIZER_PARITY_EN
            S_PARITY: begin
                sout       = par_q;
                sout_valid = 1'b1;
                last       = 1'b1;
                din_ready  = 1'b1;
                if (din_valid) begin
                    shreg_d = din;
                    cnt_d   = CNT_LOAD;
                    par_d   = 1'b0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// Bench for bit_serializer. The reference model is a queue of pending serial
// bits: an accepted word appends its bits MSB-first (plus its parity bit when
// parity is built in), and each clock edge retires the bit at the head. The
// expected outputs follow directly: sout is the head bit, last is "one bit
// left", din_ready is "at most one bit left".
// -----------------------------------------------------------------------------
module tb_bit_serializer;

  localparam int WIDTH = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int WLEN = WIDTH + (PAR_EN ? 1 : 0);

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;
  logic             din_ready, sout, sout_valid, last, busy;
  logic [1:0]       dbg_state;

  logic [WIDTH-1:0] din1 = '0;
  logic             din_valid1 = 1'b0;
  logic             din_ready1, sout1, sout_valid1, last1, busy1;
  logic [1:0]       dbg_state1;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(WIDTH), .IDLE_BIT(1'b0)) u_dut (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .sout(sout), .sout_valid(sout_valid),
    .last(last), .busy(busy), .dbg_state_o(dbg_state)
  );

  bit_serializer #(.WIDTH(WIDTH), .IDLE_BIT(1'b1)) u_idle1 (
    .clk(clk), .rstn(rstn), .din(din1), .din_valid(din_valid1),
    .din_ready(din_ready1), .sout(sout1), .sout_valid(sout_valid1),
    .last(last1), .busy(busy1), .dbg_state_o(dbg_state1)
  );

  // ---------------- scoreboard ----------------
  logic [0:0]  exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic        last_acc = 1'b0;
  logic [63:0] cap_sout, cap_last, cap_rdy, cap_vld;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic exp_sout;
    exp_sout = (exp_q.size() > 0) ? exp_q[0][0] : 1'b0;
    check("sout", {63'd0, sout}, {63'd0, exp_sout});
    check("sout_valid", {63'd0, sout_valid}, {63'd0, exp_q.size() > 0});
    check("last", {63'd0, last}, {63'd0, exp_q.size() == 1});
    check("busy", {63'd0, busy}, {63'd0, exp_q.size() > 0});
    check("din_ready", {63'd0, din_ready}, {63'd0, exp_q.size() <= 1});
  endtask

  task automatic cap_clear();
    cap_sout = '0; cap_last = '0; cap_rdy = '0; cap_vld = '0;
  endtask

  function automatic logic [63:0] mask(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  // One clock: model update at the edge, then sample 1 time unit later.
  task automatic cyc();
    logic acc;
    acc = rstn && din_valid && (exp_q.size() <= 1);
    @(posedge clk);
    if (!rstn) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
        for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(din[i]);
        if (PAR_EN) exp_q.push_back(^din);
      end
    end
    last_acc = acc;
    #1;
    cap_sout = {cap_sout[62:0], sout};
    cap_last = {cap_last[62:0], last};
    cap_rdy  = {cap_rdy[62:0], din_ready};
    cap_vld  = {cap_vld[62:0], sout_valid};
    check_model();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_bits;  // serial order, first bit in [7]
    logic       exp_par;
  } vec_t;

  vec_t vecs[9];

  logic [63:0] e;
  int          acc_idx;

  initial begin
    vecs[0] = '{8'hD4, 8'b1101_0100, 1'b0};
    vecs[1] = '{8'h07, 8'b0000_0111, 1'b1};
    vecs[2] = '{8'hA5, 8'b1010_0101, 1'b0};
    vecs[3] = '{8'h3C, 8'b0011_1100, 1'b0};
    vecs[4] = '{8'hFF, 8'b1111_1111, 1'b0};
    vecs[5] = '{8'h81, 8'b1000_0001, 1'b0};
    vecs[6] = '{8'h01, 8'b0000_0001, 1'b1};
    vecs[7] = '{8'h80, 8'b1000_0000, 1'b1};
    vecs[8] = '{8'h6B, 8'b0110_1011, 1'b1};
    cap_clear();

    // Reset values, including din_ready high while in reset.
    #1;
    check_model();
    check("idle1_sout_rst", {63'd0, sout1}, 64'd1);
    check("idle1_ready_rst", {63'd0, din_ready1}, 64'd1);
    cyc();
    cyc();
    rstn = 1'b1;

    // IDLE_BIT=1 instance stays idle at level 1.
    for (int k = 0; k < 20; k++) begin
      cyc();
      check("idle1_sout", {63'd0, sout1}, 64'd1);
      check("idle1_valid", {63'd0, sout_valid1}, 64'd0);
      check("idle1_busy", {63'd0, busy1}, 64'd0);
    end

    // Single words from the table.
    foreach (vecs[i]) begin
      cap_clear();
      din = vecs[i].word;
      din_valid = 1'b1;
      cyc();
      din_valid = 1'b0;
      for (int k = 1; k < WLEN; k++) cyc();
      e = PAR_EN ? {55'd0, vecs[i].exp_bits, vecs[i].exp_par} : {56'd0, vecs[i].exp_bits};
      check("vec_bits", cap_sout & mask(WLEN), e);
      check("vec_last", cap_last & mask(WLEN), 64'd1);
      check("vec_valid", cap_vld & mask(WLEN), mask(WLEN));
      cyc();
      check("vec_after_sout", {63'd0, sout}, 64'd0);
      check("vec_after_valid", {63'd0, sout_valid}, 64'd0);
      check("vec_after_ready", {63'd0, din_ready}, 64'd1);
    end

    // Back-to-back words with din_valid held high.
    cap_clear();
    din = 8'hA5;
    din_valid = 1'b1;
    cyc();
    din = 8'h3C;
    for (int k = 1; k < 2 * WLEN; k++) begin
      cyc();
      if (last_acc) din_valid = 1'b0;
    end
`ifdef SERIALIZER_PARITY_EN
    check("b2b_bits", cap_sout & mask(18), {46'd0, 8'hA5, 1'b0, 8'h3C, 1'b0});
    check("b2b_ready", cap_rdy & mask(18), {46'd0, 9'b0_0000_0001, 9'b0_0000_0001});
`else
    check("b2b_bits", cap_sout & mask(16), 64'h0000_0000_0000_A53C);
    check("b2b_ready", cap_rdy & mask(16), 64'h0000_0000_0000_0101);
`endif
    check("b2b_last", cap_last & mask(2 * WLEN), cap_rdy & mask(2 * WLEN) & {64{1'b1}} & ((64'd1 << WLEN) | 64'd1));
    cyc();

    // din_valid raised mid-word: held off until the final bit cycle.
    cap_clear();
    din = 8'h00;
    din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    acc_idx = -1;
    for (int k = 1; k < 2 * WLEN; k++) begin
      if (k == 3) begin
        din = 8'hFF;
        din_valid = 1'b1;
      end
      cyc();
      if (last_acc) begin
        acc_idx = k;
        din_valid = 1'b0;
      end
    end
    check("mid_accept_cycle", 64'(acc_idx), 64'(WLEN));
`ifdef SERIALIZER_PARITY_EN
    check("mid_bits", cap_sout & mask(18), {46'd0, 8'h00, 1'b0, 8'hFF, 1'b0});
`else
    check("mid_bits", cap_sout & mask(16), 64'h0000_0000_0000_00FF);
`endif
    cyc();

`ifdef SERIALIZER_PARITY_EN
    // Parity words back to back.
    cap_clear();
    din = 8'hD4;
    din_valid = 1'b1;
    cyc();
    din = 8'h07;
    for (int k = 1; k < 18; k++) begin
      cyc();
      if (last_acc) din_valid = 1'b0;
    end
    check("par_bits", cap_sout & mask(18), {46'd0, 8'hD4, 1'b0, 8'h07, 1'b1});
    check("par_last", cap_last & mask(18), {46'd0, 9'b0_0000_0001, 9'b0_0000_0001});
    cyc();
`endif

    // Asynchronous reset at bit 3 of 8'hD4, then a clean 8'h81.
    cap_clear();
    din = 8'hD4;
    din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    for (int k = 1; k <= 3; k++) cyc();
    #2;
    rstn = 1'b0;
    #1;
    exp_q.delete();
    check_model();
    cyc();
    rstn = 1'b1;
    cyc();
    cyc();
    cap_clear();
    din = 8'h81;
    din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    for (int k = 1; k < WLEN; k++) cyc();
    e = PAR_EN ? {55'd0, 8'h81, 1'b0} : {56'd0, 8'h81};
    check("post_rst_bits", cap_sout & mask(WLEN), e);
    cyc();

    // Randomized traffic against the queue model.
    for (int k = 0; k < 400; k++) begin
      if (!din_valid && ($urandom_range(0, 2) != 0)) begin
        din = WIDTH'($urandom);
        din_valid = 1'b1;
      end
      cyc();
      if (last_acc) din_valid = 1'b0;
    end
    din_valid = 1'b0;
    for (int k = 0; k < WLEN + 2; k++) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the sequence-detector path. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on a single-bit line. That line connects directly to the detector's one-bit serial input, which samples it every cycle. Back-to-back words stream with no idle gap, so bit patterns that span word boundaries reach the detector intact.

## Interface
- WIDTH, 8 — word width in bits; legal range 2..32.
- IDLE_BIT, 1'b0 — level driven on `sout` whenever no word is being shifted.

- clk  input  1  — single clock; all state updates on posedge.
- rstn  input  1  — asynchronous, active-low reset; deasserted synchronously to clk externally.
- din  input  WIDTH  — parallel word, sampled on accept.
- din_valid  input  1  — `din` holds a word.
- din_ready  output  1  — block can accept a word this cycle.
- sout  output  1  — serial bit; feeds the detector's `in`.
- sout_valid  output  1  — `sout` carries a data (or parity) bit, not the idle level.
- last  output  1  — current `sout` bit is the final bit of its word.
- busy  output  1  — FSM not in IDLE.

## Operation
- Accept occurs when `din_valid && din_ready` at a posedge.
  - The word loads into a WIDTH-bit shift register.
  - The bit counter loads WIDTH-1.
- FSM states (encoding free):
  - IDLE
  - SHIFT
  - PARITY (PARITY state only when the macro is on).
- IDLE:
  - `din_ready=1`, `sout=IDLE_BIT`, `sout_valid=0`.
  - On accept → SHIFT.
- SHIFT:
  - `sout` = shift-register MSB; shift left one bit per cycle; counter decrements.
  - `last=1` when counter==0 (without parity).
  - Macro off: `din_ready=1` only when counter==0.
    - Accept on that cycle reloads and stays in SHIFT (zero-bubble streaming).
    - No accept on that cycle → IDLE.
  - Macro on: `din_ready=0` throughout SHIFT; counter==0 → PARITY.
- PARITY (macro on only):
  - `sout` = even-parity bit of the word (XOR of all WIDTH bits), `sout_valid=1`, `last=1`.
  - `din_ready=1`; accept → SHIFT, else → IDLE.
- `din_valid` while `din_ready=0`: ignored, no side effects. Upstream must hold `din`/`din_valid` stable until accepted.
- All outputs are registered or decoded only from registered state. No combinational path from `din`/`din_valid` to any output, including `din_ready`.
- Reset values:
  - state=IDLE, shift register=0, counter=0, parity accumulator=0.
  - `sout=IDLE_BIT`, `sout_valid=0`, `last=0`, `busy=0`.
  - `din_ready=1`; it is decoded from state, so it is high during reset.
- Reset mid-word: the partial word is discarded immediately (asynchronously). No partial bits resume after release.

## Timing
- Accept at edge N → word MSB on `sout` from edge N through edge N+1 (1-cycle latency).
- Bit k (MSB=0) is driven during cycle N+k.
- Final data bit is driven at cycle N+WIDTH-1.
- Parity bit, when present, is driven at cycle N+WIDTH.
- Throughput:
  - Macro off: one word per WIDTH cycles.
  - Macro on: one word per WIDTH+1 cycles.
- Streaming: next word's MSB follows the previous word's last bit in the very next cycle, provided `din_valid` is high when `last=1`.
- Counter width is $clog2(WIDTH); it never wraps below 0 because it is reloaded or FSM exits at 0.

## Configuration
- `SERIALIZER_PARITY_EN` defined: PARITY state present; each word is followed by one even-parity bit with `sout_valid=1`, `last=1`.
- Not defined: no PARITY state, no parity logic; words are WIDTH bits with zero-bubble streaming.

## Test plan
- Reset then single word 8'hD4, macro off:
  - `sout` = 1,1,0,1,0,1,0,0 on cycles N..N+7; `last` only on N+7.
  - Then `sout=0`, `sout_valid=0`, `din_ready=1`.
  - Downstream detector fires once.
- Back-to-back 8'hA5 then 8'h3C, `din_valid` held high:
  - 16 contiguous bits 1010_0101_0011_1100 with no gap.
  - `din_ready` high only in IDLE and on the two `last` cycles.
- `din_valid` asserted mid-word with 8'hFF:
  - Not accepted until the `last` cycle.
  - Earlier cycles leave the shift register and counter unchanged.
- Macro on, 8'hD4 then 8'h07:
  - Parity bit 0 after the first word and 1 after the second.
  - Each word occupies 9 cycles; `last` is on the parity bits only.
- `rstn` pulled low at bit 3 of 8'hD4:
  - Outputs return to reset values immediately (asynchronous).
  - After release, the next accepted 8'h81 serializes cleanly with no residue.
- IDLE_BIT=1, no input for 20 cycles:
  - `sout` holds 1, `sout_valid=0`, `busy=0` throughout.
